axis_pkt_rr_pacer: RTL

- Packet-granular round-robin scheduler sharing one AXI-Stream output among NUM_PORTS input streams.
- Adds programmable idle gaps between granted beats and between packets.
- Sits in front of the pacing/FIFO stage: sequences which source owns the datapath and when it may transmit.
- A grant is held from first beat to tlast; no interleaving within a packet.

---
 rtl/axis_pkt_rr_pacer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_rr_pacer.sv
// axis_pkt_rr_pacer
//   Packet-granular round-robin scheduler that shares one AXI-Stream output
//   among NUM_PORTS input streams. A grant is held from the first beat to
//   tlast. Programmable idle gaps are inserted after each accepted non-last
//   beat (cfg_beat_gap) and after each accepted tlast beat (cfg_pkt_gap).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_enable          allow new grants (an in-flight packet always completes)
//   cfg_beat_gap        idle cycles after each accepted non-last beat
//   cfg_pkt_gap         idle cycles after each accepted tlast beat
//   s_axis_*            flattened input streams, port i at slice i
//   m_axis_*            shared output stream
//   grant_idx           currently / last granted port
//   busy                high while a packet or one of its gaps is in progress
//   pkt_count           total forwarded packets, wraps at 2^32
//
// Optional build macro AXIS_PKT_RR_PACER_STATS_EN adds:
//   port_pkt_count      per-port wrapping packet counters (32 bits each)
//   stall_cycles        saturating count of XFER cycles with tvalid && !tready
module axis_pkt_rr_pacer #(
    parameter int NUM_PORTS   = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 1,
    parameter int GAP_W       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_enable,
    input  logic [GAP_W-1:0]                      cfg_beat_gap,
    input  logic [GAP_W-1:0]                      cfg_pkt_gap,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [NUM_PORTS*TDATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                  s_axis_tready,
    output logic [TDATA_WIDTH-1:0]                m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]              m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]                m_axis_tuser,
    output logic                                  m_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [$clog2(NUM_PORTS)-1:0]          grant_idx,
    output logic                                  busy,
    output logic [31:0]                           pkt_count
`ifdef AXIS_PKT_RR_PACER_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]               port_pkt_count,
    output logic [31:0]                           stall_cycles
`endif
);

    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int KEEP_W = TDATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, XFER, BEAT_GAP, PKT_GAP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]      pkt_count_q, pkt_count_d;

    // Round-robin search: first valid port starting at rr_ptr, wrapping.
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (!found && s_axis_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Datapath is a plain mux on the held grant; only tvalid is state-gated.
    logic xfer, sel_tvalid, sel_tlast, beat_acc;

    assign xfer          = (state_q == XFER);
    assign sel_tvalid    = s_axis_tvalid[grant_idx_q];
    assign sel_tlast     = s_axis_tlast[grant_idx_q];
    assign m_axis_tdata  = s_axis_tdata[int'(grant_idx_q)*TDATA_WIDTH +: TDATA_WIDTH];
    assign m_axis_tkeep  = s_axis_tkeep[int'(grant_idx_q)*KEEP_W +: KEEP_W];
    assign m_axis_tuser  = s_axis_tuser[int'(grant_idx_q)*TUSER_WIDTH +: TUSER_WIDTH];
    assign m_axis_tlast  = sel_tlast;
    assign m_axis_tvalid = xfer && sel_tvalid;
    assign beat_acc      = m_axis_tvalid && m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        if (xfer) s_axis_tready[grant_idx_q] = m_axis_tready;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (cfg_enable && found) begin
                    grant_idx_d = pick;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (beat_acc) begin
                    if (sel_tlast) begin
                        rr_ptr_d    = (grant_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                            : grant_idx_q + IDX_W'(1);
                        pkt_count_d = pkt_count_q + 32'd1;
                        if (cfg_pkt_gap != '0) begin
                            gap_cnt_d = cfg_pkt_gap;
                            state_d   = PKT_GAP;
                        end else begin
                            state_d   = IDLE;
                        end
                    end else if (cfg_beat_gap != '0) begin
                        gap_cnt_d = cfg_beat_gap;
                        state_d   = BEAT_GAP;
                    end
                end
            end
            BEAT_GAP, PKT_GAP: begin
                // Counter was loaded with N; leaving on 1 gives exactly N idle cycles.
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) state_d = (state_q == BEAT_GAP) ? XFER : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            gap_cnt_q   <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign grant_idx = grant_idx_q;
    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_count_q;

`ifdef AXIS_PKT_RR_PACER_STATS_EN
    logic [NUM_PORTS-1:0][31:0] port_cnt_q, port_cnt_d;
    logic [31:0]                stall_q, stall_d;

    always_comb begin
        port_cnt_d = port_cnt_q;
        stall_d    = stall_q;
        if (beat_acc && sel_tlast)
            port_cnt_d[grant_idx_q] = port_cnt_q[grant_idx_q] + 32'd1;
        if (m_axis_tvalid && !m_axis_tready && (stall_q != '1))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            port_cnt_q <= port_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign port_pkt_count = port_cnt_q;
    assign stall_cycles   = stall_q;
`endif

endmodule
